// File: rtl/chacha_core_iter.sv
// chacha_core_iter: iterative ChaCha block core, one half-round (four parallel quarter-rounds) per clock,
// with multi-block requests that step the block counter between blocks.
module chacha_core_iter #(
    parameter int ROUNDS  = 20,
    parameter bit FEEDFWD = 1'b1,
    parameter bit CTR64   = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] state_in,
    input  logic [7:0]   in_nblocks,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] state_out,
    output logic         out_last,
    output logic         busy
);
    if (!(ROUNDS == 8 || ROUNDS == 12 || ROUNDS == 20)) begin : g_bad_rounds
        $error("chacha_core_iter: ROUNDS must be 8, 12 or 20");
    end

    typedef enum logic [1:0] {IDLE, ROUND, OUT} state_t;
    typedef logic [0:15][31:0] words_t;

    state_t     state, state_nxt;
    words_t     base, work, half, base_inc, fin;
    logic [7:0] rem;
    logic [4:0] rc;
    logic       armed, accept, last_round;
    logic [1:0] s1, s2, s3, j;
    logic [3:0] ai, bi, ci, di;
    logic [0:3][31:0] q;

    function automatic logic [0:3][31:0] qr(input logic [31:0] a, b, c, d);
        a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
        c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
        a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
        c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
        return {a, b, c, d};
    endfunction

    // armed keeps in_ready low until the first edge after reset release
    assign in_ready   = armed && state == IDLE;
    assign accept     = in_valid && in_ready;
    assign out_valid  = state == OUT;
    assign out_last   = out_valid && rem == 8'd1;
    assign busy       = state != IDLE;
    assign last_round = rc == 5'(ROUNDS);

    // odd rounds rotate the b/c/d rows by 1/2/3 lanes to form the diagonals
    assign s1 = {1'b0, rc[0]};
    assign s2 = {rc[0], 1'b0};
    assign s3 = {2{rc[0]}};

    always_comb begin
        half = work;
        q  = '0;
        j  = '0;
        ai = '0;
        bi = '0;
        ci = '0;
        di = '0;
        for (int i = 0; i < 4; i++) begin
            j  = i[1:0];
            ai = {2'd0, j};
            bi = {2'd1, j + s1};
            ci = {2'd2, j + s2};
            di = {2'd3, j + s3};
            q  = qr(work[ai], work[bi], work[ci], work[di]);
            half[ai] = q[0];
            half[bi] = q[1];
            half[ci] = q[2];
            half[di] = q[3];
        end
    end

    always_comb begin
        fin = work;
        for (int i = 0; i < 16; i++)
            fin[i[3:0]] = FEEDFWD ? work[i[3:0]] + base[i[3:0]] : work[i[3:0]];
    end

    always_comb begin
        base_inc = base;
        if (CTR64)
            {base_inc[13], base_inc[12]} = {base[13], base[12]} + 64'd1;
        else
            base_inc[12] = base[12] + 32'd1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ROUND;
            ROUND:   if (last_round) state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = rem == 8'd1 ? IDLE : ROUND;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed     <= 1'b0;
            base      <= '0;
            work      <= '0;
            rem       <= '0;
            rc        <= '0;
            state_out <= '0;
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE: if (accept) begin
                    base <= state_in;
                    work <= state_in;
                    rem  <= in_nblocks == 8'd0 ? 8'd1 : in_nblocks;
                    rc   <= '0;
                end
                ROUND: if (last_round) begin
                    state_out <= fin;
                end else begin
                    work <= half;
                    rc   <= rc + 5'd1;
                end
                OUT: if (out_ready && rem != 8'd1) begin
                    rem  <= rem - 8'd1;
                    base <= base_inc;
                    work <= base_inc;
                    rc   <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_chacha_core_iter.sv
// tb_chacha_core_iter: directed bench for chacha_core_iter using five parameter variants on shared inputs;
// expected blocks come from the RFC 7539 vector and an independent ChaCha reference function.
module tb_chacha_core_iter;
    typedef logic [0:15][31:0] st_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] in_nblocks = 8'd1;
    st_t        state_in = '0;
    logic [4:0] ir, ov, ol, bz;
    st_t        so [5];

    int   n_assert = 0;
    int   n_fail = 0;
    int   lat [5];
    st_t  cap [5];
    logic capl [5];

    always #5 clk = ~clk;

    // 0: defaults, 1: 64-bit counter, 2: no feed-forward, 3: 8 rounds, 4: 12 rounds
    chacha_core_iter #(.ROUNDS(20), .FEEDFWD(1), .CTR64(0)) u0 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
        .state_in(state_in), .in_nblocks(in_nblocks), .out_valid(ov[0]), .out_ready(out_ready), .state_out(so[0]), .out_last(ol[0]), .busy(bz[0]));
    chacha_core_iter #(.ROUNDS(20), .FEEDFWD(1), .CTR64(1)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
        .state_in(state_in), .in_nblocks(in_nblocks), .out_valid(ov[1]), .out_ready(out_ready), .state_out(so[1]), .out_last(ol[1]), .busy(bz[1]));
    chacha_core_iter #(.ROUNDS(20), .FEEDFWD(0), .CTR64(0)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
        .state_in(state_in), .in_nblocks(in_nblocks), .out_valid(ov[2]), .out_ready(out_ready), .state_out(so[2]), .out_last(ol[2]), .busy(bz[2]));
    chacha_core_iter #(.ROUNDS(8), .FEEDFWD(1), .CTR64(0)) u3 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[3]),
        .state_in(state_in), .in_nblocks(in_nblocks), .out_valid(ov[3]), .out_ready(out_ready), .state_out(so[3]), .out_last(ol[3]), .busy(bz[3]));
    chacha_core_iter #(.ROUNDS(12), .FEEDFWD(1), .CTR64(0)) u4 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[4]),
        .state_in(state_in), .in_nblocks(in_nblocks), .out_valid(ov[4]), .out_ready(out_ready), .state_out(so[4]), .out_last(ol[4]), .busy(bz[4]));

    function automatic logic [31:0] rotl(logic [31:0] v, int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic st_t qrf(st_t x, logic [3:0] a, logic [3:0] b, logic [3:0] c, logic [3:0] d);
        x[a] += x[b]; x[d] = rotl(x[d] ^ x[a], 16);
        x[c] += x[d]; x[b] = rotl(x[b] ^ x[c], 12);
        x[a] += x[b]; x[d] = rotl(x[d] ^ x[a], 8);
        x[c] += x[d]; x[b] = rotl(x[b] ^ x[c], 7);
        return x;
    endfunction

    function automatic st_t ref_block(st_t s, int rounds, bit ff);
        st_t x = s;
        for (int r = 0; r < rounds; r++) begin
            if (r % 2 == 0) begin
                x = qrf(x, 4'd0, 4'd4, 4'd8, 4'd12);
                x = qrf(x, 4'd1, 4'd5, 4'd9, 4'd13);
                x = qrf(x, 4'd2, 4'd6, 4'd10, 4'd14);
                x = qrf(x, 4'd3, 4'd7, 4'd11, 4'd15);
            end else begin
                x = qrf(x, 4'd0, 4'd5, 4'd10, 4'd15);
                x = qrf(x, 4'd1, 4'd6, 4'd11, 4'd12);
                x = qrf(x, 4'd2, 4'd7, 4'd8, 4'd13);
                x = qrf(x, 4'd3, 4'd4, 4'd9, 4'd14);
            end
        end
        if (ff)
            for (int i = 0; i < 16; i++) x[i[3:0]] += s[i[3:0]];
        return x;
    endfunction

    function automatic st_t with_ctr(st_t s, logic [31:0] w12, logic [31:0] w13);
        s[12] = w12;
        s[13] = w13;
        return s;
    endfunction

    task automatic check(string tag, logic [511:0] obs, logic [511:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // leaves the bench 1 time unit after the accepting edge
    task automatic send(st_t s, logic [7:0] n);
        @(posedge clk); #1;
        state_in = s;
        in_nblocks = n;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // records, per instance, the first block seen within 30 edges and its edge count
    task automatic collect();
        for (int j = 0; j < 5; j++) begin
            lat[j] = 0;
            cap[j] = '0;
            capl[j] = 1'b0;
        end
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            for (int j = 0; j < 5; j++)
                if (lat[j] == 0 && ov[j[2:0]]) begin
                    lat[j] = k;
                    cap[j] = so[j];
                    capl[j] = ol[j[2:0]];
                end
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 100 && bz != 5'd0; k++) begin
            @(posedge clk); #1;
        end
        check("idle_after_request", bz, 5'd0);
    endtask

    initial begin
        st_t rfc, s5, exp0;
        int  blk, seen;
        int  cnt [2];
        rfc = {32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
               32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
               32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
               32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};
        exp0 = ref_block(rfc, 20, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", ir, 5'd0);
        check("reset_out_valid", ov, 5'd0);
        check("reset_out_last", ol, 5'd0);
        check("reset_busy", bz, 5'd0);
        check("reset_state_out", so[0], 512'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_release", ir, 5'h1f);

        send(rfc, 8'd1);
        collect();
        check("rfc_word0", cap[0][0], 32'he4e7f110);
        check("rfc_word1", cap[0][1], 32'h15593bd1);
        check("rfc_word15", cap[0][15], 32'h4e3c50a2);
        check("rfc_block", cap[0], exp0);
        check("rfc_block_ctr64", cap[1], exp0);
        check("rfc_raw_block", cap[2], ref_block(rfc, 20, 1'b0));
        check("rfc_block_r8", cap[3], ref_block(rfc, 8, 1'b1));
        check("rfc_block_r12", cap[4], ref_block(rfc, 12, 1'b1));
        check("latency_r20", lat[0], 21);
        check("latency_r20_raw", lat[2], 21);
        check("latency_r8", lat[3], 9);
        check("latency_r12", lat[4], 13);
        check("single_block_last", capl[0], 1'b1);

        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            state_in = '1;
            in_nblocks = 8'd5;
            @(posedge clk); #1;
            check("stall_out_valid", ov[0], 1'b1);
            check("stall_state_out", so[0], exp0);
            check("stall_out_last", ol[0], 1'b1);
            check("stall_in_ready", ir[0], 1'b0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("drop_after_last", ov[0], 1'b0);
        check("idle_after_last", bz[0], 1'b0);
        check("ready_after_last", ir[0], 1'b1);

        send(rfc, 8'd3);
        blk = 0;
        for (int k = 1; k <= 100 && blk < 3; k++) begin
            @(posedge clk); #1;
            if (ov[0]) begin
                blk++;
                check("multi_block", so[0], ref_block(with_ctr(rfc, blk, 32'h09000000), 20, 1'b1));
                check("multi_last", ol[0], blk == 3);
                check("multi_latency", k, 21 + (blk - 1) * 22);
            end
        end
        check("multi_block_count", blk, 3);
        wait_idle();

        s5 = with_ctr(rfc, 32'hffffffff, 32'h00000007);
        send(s5, 8'd2);
        cnt[0] = 0;
        cnt[1] = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            for (int j = 0; j < 2; j++)
                if (ov[j[2:0]]) begin
                    cnt[j]++;
                    if (cnt[j] == 1)
                        check("wrap_first", so[j], ref_block(s5, 20, 1'b1));
                    else
                        check(j == 0 ? "wrap_ctr32" : "wrap_ctr64", so[j],
                              ref_block(with_ctr(s5, 32'h0, j == 0 ? 32'h7 : 32'h8), 20, 1'b1));
                end
        end
        check("wrap_count_ctr32", cnt[0], 2);
        check("wrap_count_ctr64", cnt[1], 2);
        wait_idle();

        send(rfc, 8'd1);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", ov, 5'd0);
        check("abort_busy", bz, 5'd0);
        check("abort_in_ready", ir, 5'd0);
        check("abort_state_out", so[0], 512'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_abort", ir, 5'h1f);
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (ov != 5'd0) seen++;
        end
        check("no_block_after_abort", seen, 0);
        send(rfc, 8'd1);
        collect();
        check("block_after_abort", cap[0], exp0);
        check("latency_after_abort", lat[0], 21);

        send('0, 8'd0);
        collect();
        check("zero_ff", cap[0], 512'd0);
        check("zero_raw", cap[2], 512'd0);
        check("zero_r8", cap[3], 512'd0);
        check("zero_r12", cap[4], 512'd0);
        check("zero_latency_r20", lat[0], 21);
        check("nblocks0_last", capl[0], 1'b1);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
